// File: rtl/ram_multi_read_port.sv
// rtl/ram_multi_read_port.sv - multi-read-port synchronous RAM with byte enables and clear engine
// Zero walk runs after reset or on iClear; reads and writes are accepted only once it has finished.
module ram_multi_read_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 256,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1,
  parameter int OUT_REG    = 0
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             iClear,
  input  logic                             iWriteEnable,
  input  logic [DATA_WIDTH/8-1:0]          iByteEnable,
  input  logic [ADDR_WIDTH-1:0]            iWriteAddress,
  input  logic [DATA_WIDTH-1:0]            iDataIn,
  input  logic [READ_PORTS-1:0]            iReadEnable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0] oDataOut,
  output logic [READ_PORTS-1:0]            oReadValid,
  output logic                             oBusy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0] L_SIZE = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [IDX_W-1:0]    L_LAST = IDX_W'(MEM_SIZE - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                                 r_state, w_state_next;
  logic [IDX_W-1:0]                       r_clr_addr, w_clr_addr_next;
  logic [DATA_WIDTH-1:0]                  r_mem [MEM_SIZE];
  logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  r_rd_data, w_rd_word;
  logic [READ_PORTS-1:0]                  r_rd_valid, w_rd_in_range;
  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  w_rd_addr;
  logic                                   w_idle, w_user_wr;
  logic [IDX_W-1:0]                       w_mem_idx;
  logic [NB-1:0]                          w_mem_be;
  logic [DATA_WIDTH-1:0]                  w_mem_wdata;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_addr == L_LAST) w_state_next = S_IDLE;
        else                      w_clr_addr_next = r_clr_addr + IDX_W'(1);
      end
      S_IDLE: begin
        if (iClear) begin
          w_state_next    = S_CLEAR;
          w_clr_addr_next = '0;
        end
      end
      default: w_state_next = S_CLEAR;
    endcase
  end

  assign w_idle    = (r_state == S_IDLE);
  assign oBusy     = ~w_idle;
  assign w_user_wr = w_idle & iWriteEnable & ({1'b0, iWriteAddress} < L_SIZE);

  // The clear walk and user writes share the single array write port.
  assign w_mem_idx   = w_idle ? iWriteAddress[IDX_W-1:0] : r_clr_addr;
  assign w_mem_be    = w_idle ? (w_user_wr ? iByteEnable : '0) : '1;
  assign w_mem_wdata = w_idle ? iDataIn : '0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  assign w_rd_addr = iReadAddress;

  always_comb begin
    w_rd_in_range = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      w_rd_in_range[p] = ({1'b0, w_rd_addr[p]} < L_SIZE);
    end
  end

  // Write-first builds merge the enabled incoming bytes over the stored word.
  always_comb begin
    w_rd_word = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (w_rd_in_range[p]) begin
        w_rd_word[p] = r_mem[w_rd_addr[p][IDX_W-1:0]];
        if (BYPASS != 0 && w_user_wr && w_rd_addr[p] == iWriteAddress) begin
          for (int b = 0; b < NB; b++) begin
            if (iByteEnable[b]) w_rd_word[p][8*b +: 8] = iDataIn[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (w_idle && iReadEnable[p]) begin
          r_rd_data[p]  <= w_rd_word[p];
          r_rd_valid[p] <= 1'b1;
        end else begin
          r_rd_valid[p] <= 1'b0;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [READ_PORTS*DATA_WIDTH-1:0] r_out_data;
      logic [READ_PORTS-1:0]            r_out_valid;

      always_ff @(posedge Clock) begin
        if (!Reset) begin
          r_out_data  <= '0;
          r_out_valid <= '0;
        end else begin
          r_out_data  <= r_rd_data;
          r_out_valid <= r_rd_valid;
        end
      end

      assign oDataOut   = r_out_data;
      assign oReadValid = r_out_valid;
    end else begin : g_out_direct
      assign oDataOut   = r_rd_data;
      assign oReadValid = r_rd_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_multi_read_port.sv
// tb/tb_ram_multi_read_port.sv - directed bench for ram_multi_read_port
// dut_a: write-first with output register; dut_b: read-first without; both share all inputs.
module tb_ram_multi_read_port;

  logic        clk = 1'b0;
  logic        rst_n, clr, we;
  logic [1:0]  be;
  logic [8:0]  waddr;
  logic [15:0] din;
  logic [2:0]  re;
  logic [26:0] raddr;
  logic [47:0] dout_a, dout_b;
  logic [2:0]  valid_a, valid_b;
  logic        busy_a, busy_b;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int seen;

  always #5 clk = ~clk;

  ram_multi_read_port #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MEM_SIZE(256), .READ_PORTS(3),
                        .BYPASS(1), .OUT_REG(1)) dut_a (
    .Clock(clk), .Reset(rst_n), .iClear(clr), .iWriteEnable(we), .iByteEnable(be),
    .iWriteAddress(waddr), .iDataIn(din), .iReadEnable(re), .iReadAddress(raddr),
    .oDataOut(dout_a), .oReadValid(valid_a), .oBusy(busy_a));

  ram_multi_read_port #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .MEM_SIZE(256), .READ_PORTS(3),
                        .BYPASS(0), .OUT_REG(0)) dut_b (
    .Clock(clk), .Reset(rst_n), .iClear(clr), .iWriteEnable(we), .iByteEnable(be),
    .iWriteAddress(waddr), .iDataIn(din), .iReadEnable(re), .iReadAddress(raddr),
    .oDataOut(dout_b), .oReadValid(valid_b), .oBusy(busy_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] m);
    waddr = a; din = d; be = m; we = 1'b1;
    tick;
    we = 1'b0;
  endtask

  // After return dut_b shows the read; dut_a needs one further tick.
  task automatic issue_read(input logic [8:0] a0, input logic [8:0] a1, input logic [8:0] a2,
                            input logic [2:0] en);
    raddr = {a2, a1, a0}; re = en;
    tick;
    re = 3'b000;
  endtask

  task automatic count_busy(output int cycles, output int saw_valid);
    cycles = 0; saw_valid = 0;
    while (busy_a && cycles < 1000) begin
      clr = (cycles == 10);
      tick;
      we = 1'b0;
      cycles++;
      if (valid_a != 3'b000 || valid_b != 3'b000) saw_valid = 1;
    end
    clr = 1'b0; re = 3'b000;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; be = 2'b00; waddr = '0; din = '0;
    re = 3'b000; raddr = '0;
    repeat (3) tick;
    chk("reset_busy", busy_a, 1);
    chk("reset_valid", {valid_a, valid_b}, 0);
    chk("reset_dout_a", dout_a, 0);
    chk("reset_dout_b", dout_b, 0);

    // Release reset with reads requested throughout the walk.
    rst_n = 1'b1; raddr = {9'd2, 9'd1, 9'd0}; re = 3'b111;
    count_busy(n, seen);
    chk("init_busy_cycles", n, 256);
    chk("init_busy_b", busy_b, 0);
    chk("init_no_valid", seen, 0);

    issue_read(9'd0, 9'd128, 9'd255, 3'b111);
    chk("zero_read_b", dout_b, 48'h0);
    chk("zero_valid_b", valid_b, 3'b111);
    tick;
    chk("zero_read_a", dout_a, 48'h0);
    chk("zero_valid_a", valid_a, 3'b111);

    wr(9'd5, 16'hABCD, 2'b11);
    wr(9'd5, 16'h1234, 2'b01);
    issue_read(9'd5, 9'd0, 9'd0, 3'b001);
    chk("byte_en_b", dout_b[15:0], 16'hAB34);
    tick;
    chk("byte_en_a", dout_a[15:0], 16'hAB34);

    wr(9'd9, 16'h1111, 2'b11);
    waddr = 9'd9; din = 16'h2222; be = 2'b11; we = 1'b1;
    raddr = {9'd0, 9'd0, 9'd9}; re = 3'b001;
    tick;
    we = 1'b0; re = 3'b000;
    chk("rdw_read_first", dout_b[15:0], 16'h1111);
    tick;
    chk("rdw_write_first", dout_a[15:0], 16'h2222);
    issue_read(9'd9, 9'd0, 9'd0, 3'b001);
    chk("rdw_next_b", dout_b[15:0], 16'h2222);
    tick;
    chk("rdw_next_a", dout_a[15:0], 16'h2222);

    wr(9'd1, 16'hBEEF, 2'b11);
    issue_read(9'd1, 9'd1, 9'd300, 3'b111);
    chk("multi_b", dout_b, {16'h0000, 16'hBEEF, 16'hBEEF});
    chk("multi_valid_b", valid_b, 3'b111);
    tick;
    chk("multi_a", dout_a, {16'h0000, 16'hBEEF, 16'hBEEF});
    chk("multi_valid_a", valid_a, 3'b111);

    issue_read(9'd0, 9'd5, 9'd0, 3'b010);
    chk("hold_b", dout_b, {16'h0000, 16'hAB34, 16'hBEEF});
    chk("hold_valid_b", valid_b, 3'b010);
    tick;
    chk("hold_a", dout_a, {16'h0000, 16'hAB34, 16'hBEEF});
    chk("hold_valid_a", valid_a, 3'b010);

    // Out-of-range write must not alias onto 300 mod 256 = 44; empty mask is a no-op.
    wr(9'd300, 16'hFFFF, 2'b11);
    wr(9'd5, 16'h0000, 2'b00);
    issue_read(9'd5, 9'd44, 9'd0, 3'b011);
    chk("oob_write_b", dout_b[31:0], {16'h0000, 16'hAB34});
    tick;
    chk("oob_write_a", dout_a[31:0], {16'h0000, 16'hAB34});

    for (int i = 0; i < 4; i++) wr(9'(i), 16'hFFFF, 2'b11);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("clr_busy_start", busy_a, 1);
    waddr = 9'd2; din = 16'h5555; be = 2'b11; we = 1'b1; re = 3'b111;
    count_busy(n, seen);
    chk("clr_busy_cycles", n, 256);
    chk("clr_no_valid", seen, 0);
    issue_read(9'd0, 9'd1, 9'd2, 3'b111);
    chk("clr_read_b", dout_b, 48'h0);
    tick;
    chk("clr_read_a", dout_a, 48'h0);
    issue_read(9'd3, 9'd0, 9'd0, 3'b001);
    tick;
    chk("clr_read3", {dout_a[15:0], dout_b[15:0]}, 32'h0);

    wr(9'd5, 16'hAB34, 2'b11);
    issue_read(9'd5, 9'd0, 9'd0, 3'b001);
    tick;
    chk("pre_reset_data", {dout_a[15:0], dout_b[15:0]}, {16'hAB34, 16'hAB34});
    clr = 1'b1;
    tick;
    clr = 1'b0;
    repeat (100) tick;
    chk("midclear_hold", {busy_a, dout_a[15:0]}, {1'b1, 16'hAB34});
    rst_n = 1'b0;
    tick;
    chk("midreset_dout", {dout_a, dout_b}, 96'h0);
    chk("midreset_valid", {valid_a, valid_b}, 6'h0);
    tick;
    rst_n = 1'b1;
    count_busy(n, seen);
    chk("restart_busy_cycles", n, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
